// File: rtl/alu_ram_sequencer.sv
// Sequences one ALU operation against a single-port synchronous RAM per command:
// read A, read B, execute, write back, then report the result and flags.
//
// state   | meaning
// S_IDLE  | ready for a command, latches op and addresses on accept
// S_RD_A  | present operand A address to RAM
// S_RD_B  | present operand B address, capture operand A data
// S_EXEC  | drive ALU with A and B data, register result/flags
// S_WRITE | write result to destination (suppressed for illegal ops)
// S_DONE  | pulse done (and err for illegal ops), flags visible
module alu_ram_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [2:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_addr_a,
    input  logic [ADDR_W-1:0] i_cmd_addr_b,
    input  logic [ADDR_W-1:0] i_cmd_addr_d,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [DATA_W-1:0] o_alu_in0,
    output logic [DATA_W-1:0] o_alu_in1,
    output logic [2:0]        o_alu_select,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_zero,
    input  logic              i_alu_carry,
    output logic              o_done,
    output logic              o_err,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero_flag,
    output logic              o_carry_flag
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_B  = 3'd2,
        S_EXEC  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_op;
    logic [ADDR_W-1:0]   r_addr_a;
    logic [ADDR_W-1:0]   r_addr_b;
    logic [ADDR_W-1:0]   r_addr_d;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_res;
    logic                r_zero;
    logic                r_carry;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero_flag;
    logic                r_carry_flag;
    logic                w_legal;
    logic                w_accept;

    assign w_legal  = (r_op <= 3'd4);
    assign w_accept = i_cmd_valid && o_cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_addr_a     <= '0;
            r_addr_b     <= '0;
            r_addr_d     <= '0;
            r_op_a       <= '0;
            r_res        <= '0;
            r_zero       <= 1'b0;
            r_carry      <= 1'b0;
            r_result     <= '0;
            r_zero_flag  <= 1'b0;
            r_carry_flag <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op     <= i_cmd_op;
                r_addr_a <= i_cmd_addr_a;
                r_addr_b <= i_cmd_addr_b;
                r_addr_d <= i_cmd_addr_d;
            end
            if (r_state == S_RD_B) begin
                r_op_a <= i_ram_rdata;
            end
            // Illegal ops report result 0 / zero 1 without trusting the ALU output.
            if (r_state == S_EXEC) begin
                r_res   <= w_legal ? i_alu_result : '0;
                r_zero  <= w_legal ? i_alu_zero : 1'b1;
                r_carry <= (r_op == 3'd0) && i_alu_carry;
            end
            if (r_state == S_WRITE) begin
                r_result     <= r_res;
                r_zero_flag  <= r_zero;
                r_carry_flag <= r_carry;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        o_cmd_ready  = 1'b0;
        o_ram_addr   = '0;
        o_ram_we     = 1'b0;
        o_ram_wdata  = '0;
        o_alu_in0    = '0;
        o_alu_in1    = '0;
        o_alu_select = 3'd0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cmd_ready = rst_n;
                if (w_accept) begin
                    w_next = S_RD_A;
                end
            end
            S_RD_A: begin
                o_ram_addr = r_addr_a;
                w_next     = S_RD_B;
            end
            S_RD_B: begin
                o_ram_addr = r_addr_b;
                w_next     = S_EXEC;
            end
            S_EXEC: begin
                o_alu_in0    = r_op_a;
                o_alu_in1    = i_ram_rdata;
                o_alu_select = r_op;
                w_next       = S_WRITE;
            end
            S_WRITE: begin
                if (w_legal) begin
                    o_ram_addr  = r_addr_d;
                    o_ram_we    = 1'b1;
                    o_ram_wdata = r_res;
                end
                w_next = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                o_err  = !w_legal;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign o_result     = r_result;
    assign o_zero_flag  = r_zero_flag;
    assign o_carry_flag = r_carry_flag;

endmodule
